// File: rtl/midori_mc_serial.sv
// Column-serial Midori MixColumns engine for share-wise threshold datapaths.
// Each share is transformed independently; bypass keeps the same constant latency.
module midori_mc_serial #(
  parameter int unsigned CELL_W         = 4,
  parameter int unsigned SHARES         = 3,
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mc_en,
  input  logic [SHARES*16*CELL_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SHARES*16*CELL_W-1:0] out_data,
  output logic                       busy
);

  localparam int unsigned W     = 16 * CELL_W;
  localparam int unsigned COL_W = 4 * CELL_W;
  localparam int unsigned N     = 4 / COLS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!((CELL_W == 4 || CELL_W == 8) && SHARES >= 1 && SHARES <= 4 &&
          (COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)))
    begin : g_bad_param
      $error("midori_mc_serial: illegal CELL_W/SHARES/COLS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [SHARES*W-1:0] data, data_nxt;
  logic                mode, mode_nxt;

  // out_row_i = XOR of the other three rows = (XOR of all rows) ^ row_i
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col);
    logic [CELL_W-1:0] total;
    logic [COL_W-1:0]  res;
    total = '0;
    for (int unsigned r = 0; r < 4; r++) total ^= col[r*CELL_W +: CELL_W];
    for (int unsigned r = 0; r < 4; r++) res[r*CELL_W +: CELL_W] = total ^ col[r*CELL_W +: CELL_W];
    return res;
  endfunction

  // Column 0 is the most significant column of each share.
  function automatic int unsigned col_lo(input int unsigned s, input int unsigned c);
    return s*W + W - COL_W*(c + 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      data  <= data_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data;
    mode_nxt  = mode;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          data_nxt  = in_data;
          mode_nxt  = mc_en;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int unsigned s = 0; s < SHARES; s++) begin
          for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            if (mode)
              data_nxt[col_lo(s, 32'(cnt)*COLS_PER_CYCLE + k) +: COL_W] =
                mix_col(data[col_lo(s, 32'(cnt)*COLS_PER_CYCLE + k) +: COL_W]);
          end
        end
        if (cnt == CNT_W'(N-1)) state_nxt = DONE;
        else                    cnt_nxt   = cnt + 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_data = data;

endmodule
